// File: rtl/cache_store_align_buffer.sv
// Store alignment buffer: shifts byte/half/word stores onto cache byte lanes,
// builds byte enables, optionally merges same-word stores, and queues them for the cache.

package cache_store_align_buffer_pkg;
    typedef enum logic [1:0] {
        CACHE_ACCESS_SIZE_BYTE = 2'b00,
        CACHE_ACCESS_SIZE_HALF = 2'b01,
        CACHE_ACCESS_SIZE_WORD = 2'b10
    } cache_access_size_t;
endpackage

module cache_store_align_buffer
    import cache_store_align_buffer_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int DEPTH     = 4,
    parameter bit COALESCE  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_SIZE-1:0]       in_addr_i,
    input  logic [WORD_SIZE-1:0]       in_data_i,
    input  cache_access_size_t         in_size_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ADDR_SIZE-1:0]       out_addr_o,
    output logic [WORD_SIZE-1:0]       out_data_o,
    output logic [WORD_SIZE/8-1:0]     out_byte_en_o,
    output logic                       misaligned_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int OFFSET_SIZE = $clog2(WORD_SIZE/8);
    localparam int BE_SIZE     = WORD_SIZE/8;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    logic [ADDR_SIZE-1:0]   r_addr [DEPTH];
    logic [WORD_SIZE-1:0]   r_data [DEPTH];
    logic [BE_SIZE-1:0]     r_be   [DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_misaligned;

    logic [OFFSET_SIZE-1:0] w_off;
    logic [WORD_SIZE-1:0]   w_align_data;
    logic [BE_SIZE-1:0]     w_align_be;
    logic                   w_misaligned;
    logic [ADDR_SIZE-1:0]   w_word_addr;
    logic [PTR_W-1:0]       w_tail;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_coalesce;
    logic                   w_push;
    logic                   w_merge;

    assign w_off       = in_addr_i[OFFSET_SIZE-1:0];
    assign w_word_addr = {in_addr_i[ADDR_SIZE-1:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};

    always_comb begin
        w_align_data = '0;
        w_align_be   = '0;
        w_misaligned = 1'b0;
        case (in_size_i)
            CACHE_ACCESS_SIZE_BYTE: begin
                w_align_data = WORD_SIZE'(in_data_i[7:0]) << {w_off, 3'b000};
                w_align_be   = BE_SIZE'(1) << w_off;
            end
            CACHE_ACCESS_SIZE_HALF: begin
                if (w_off[0]) begin
                    w_misaligned = 1'b1;
                end else begin
                    w_align_data = WORD_SIZE'(in_data_i[15:0]) << {w_off[1], 4'b0000};
                    w_align_be   = BE_SIZE'(2'b11) << {w_off[1], 1'b0};
                end
            end
            CACHE_ACCESS_SIZE_WORD: begin
                if (w_off != '0) begin
                    w_misaligned = 1'b1;
                end else begin
                    w_align_data = in_data_i;
                    w_align_be   = '1;
                end
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    assign empty_o       = (r_count == '0);
    assign out_valid_o   = !empty_o;
    assign in_ready_o    = (r_count != CNT_W'(DEPTH));
    assign count_o       = r_count;
    assign misaligned_o  = r_misaligned;
    assign out_addr_o    = r_addr[r_rptr];
    assign out_data_o    = r_data[r_rptr];
    assign out_byte_en_o = r_be[r_rptr];

    assign w_tail   = r_wptr - PTR_W'(1);
    assign w_accept = in_valid_i && in_ready_o;
    assign w_pop    = out_valid_o && out_ready_i;

    // A lone head that is leaving this cycle cannot absorb a merge; the store becomes a new entry.
    assign w_coalesce = COALESCE && (r_count != '0) && (r_addr[w_tail] == w_word_addr) &&
                        !((r_count == CNT_W'(1)) && w_pop);
    assign w_push  = !reset_i && w_accept && !w_misaligned && !w_coalesce;
    assign w_merge = !reset_i && w_accept && !w_misaligned && w_coalesce;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_misaligned;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage is left unreset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr[r_wptr] <= w_word_addr;
            r_data[r_wptr] <= w_align_data;
            r_be[r_wptr]   <= w_align_be;
        end else if (w_merge) begin
            for (int i = 0; i < BE_SIZE; i++) begin
                if (w_align_be[i]) begin
                    r_data[w_tail][8*i +: 8] <= w_align_data[8*i +: 8];
                end
            end
            r_be[w_tail] <= r_be[w_tail] | w_align_be;
        end
    end

endmodule

// File: tb/tb_cache_store_align_buffer.sv
// Self-checking bench for cache_store_align_buffer: alignment vector table, directed
// corner sequences, and a queue-based reference model checked every cycle.

module tb_cache_store_align_buffer;
    import cache_store_align_buffer_pkg::*;

    localparam int DEPTH    = 4;
    localparam bit COALESCE = 1'b1;

    logic               clock;
    logic               reset;
    logic               inValid;
    logic               inReady;
    logic [31:0]        inAddr;
    logic [31:0]        inData;
    cache_access_size_t inSize;
    logic               outValid;
    logic               outReady;
    logic [31:0]        outAddr;
    logic [31:0]        outData;
    logic [3:0]         outByteEn;
    logic               misaligned;
    logic [2:0]         count;
    logic               empty;

    cache_store_align_buffer #(
        .WORD_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH), .COALESCE(COALESCE)
    ) dut (
        .clk_i(clock), .reset_i(reset),
        .in_valid_i(inValid), .in_ready_o(inReady), .in_addr_i(inAddr),
        .in_data_i(inData), .in_size_i(inSize),
        .out_valid_o(outValid), .out_ready_i(outReady), .out_addr_o(outAddr),
        .out_data_o(outData), .out_byte_en_o(outByteEn),
        .misaligned_o(misaligned), .count_o(count), .empty_o(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    typedef struct {
        cache_access_size_t size;
        logic [31:0]        addr;
        logic [31:0]        data;
        logic [31:0]        expAddr;
        logic [31:0]        expData;
        logic [3:0]         expBe;
        bit                 expMis;
    } vec_t;

    entry_t scoreboard[$];
    bit     expMis;
    bit     lastAccept;
    int     errors = 0;
    int     checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lane placement written lane-by-lane rather than as shifts.
    function automatic void modelAlign(input cache_access_size_t sz, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] ad,
                                       output logic [3:0] be, output bit mis);
        logic [1:0] off;
        off = a[1:0];
        ad  = '0;
        be  = '0;
        mis = 1'b0;
        case (sz)
            CACHE_ACCESS_SIZE_BYTE: be[off] = 1'b1;
            CACHE_ACCESS_SIZE_HALF: if (off[0]) mis = 1'b1; else be = off[1] ? 4'b1100 : 4'b0011;
            CACHE_ACCESS_SIZE_WORD: if (off != 2'd0) mis = 1'b1; else be = 4'b1111;
            default: mis = 1'b1;
        endcase
        for (int lane = 0; lane < 4; lane++) begin
            if (be[lane]) begin
                case (sz)
                    CACHE_ACCESS_SIZE_BYTE: ad[8*lane +: 8] = d[7:0];
                    CACHE_ACCESS_SIZE_HALF: ad[8*lane +: 8] = d[8*(lane%2) +: 8];
                    default:                ad[8*lane +: 8] = d[8*lane +: 8];
                endcase
            end
        end
    endfunction

    // One clock: compare the DUT against the model at the falling edge, then advance the model.
    task automatic step();
        int          n;
        bit          mReady, mValid, pop, acc, mis, doPush;
        logic [31:0] ad;
        logic [3:0]  be;
        entry_t      e;
        @(negedge clock);
        n      = scoreboard.size();
        mReady = (n != DEPTH);
        mValid = (n != 0);
        checkOutput("count", 32'(count), 32'(n));
        checkOutput("in_ready", 32'(inReady), 32'(mReady));
        checkOutput("out_valid", 32'(outValid), 32'(mValid));
        checkOutput("empty", 32'(empty), 32'(n == 0));
        checkOutput("misaligned", 32'(misaligned), 32'(expMis));
        if (mValid) begin
            checkOutput("head_addr", outAddr, scoreboard[0].addr);
            checkOutput("head_data", outData, scoreboard[0].data);
            checkOutput("head_be", 32'(outByteEn), 32'(scoreboard[0].be));
        end
        lastAccept = 1'b0;
        if (reset) begin
            scoreboard.delete();
            expMis = 1'b0;
        end else begin
            pop    = mValid && outReady;
            acc    = inValid && mReady;
            doPush = 1'b0;
            lastAccept = acc;
            modelAlign(inSize, inAddr, inData, ad, be, mis);
            expMis = acc && mis;
            e.addr = inAddr & 32'hFFFF_FFFC;
            e.data = ad;
            e.be   = be;
            if (acc && !mis) begin
                if (COALESCE && n > 0 && scoreboard[n-1].addr == e.addr && !(n == 1 && pop)) begin
                    for (int lane = 0; lane < 4; lane++) begin
                        if (be[lane]) scoreboard[n-1].data[8*lane +: 8] = ad[8*lane +: 8];
                    end
                    scoreboard[n-1].be = scoreboard[n-1].be | be;
                end else begin
                    doPush = 1'b1;
                end
            end
            if (pop) void'(scoreboard.pop_front());
            if (doPush) scoreboard.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input cache_access_size_t sz, input logic [31:0] a,
                                 input logic [31:0] d, input bit rdy);
        inValid  = v;
        inSize   = sz;
        inAddr   = a;
        inData   = d;
        outReady = rdy;
        step();
    endtask

    task automatic idle(input bit rdy, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, CACHE_ACCESS_SIZE_BYTE, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{CACHE_ACCESS_SIZE_BYTE, 32'h1003, 32'h0000_00AB, 32'h1000, 32'hAB00_0000, 4'b1000, 1'b0};
        vecs[1]  = '{CACHE_ACCESS_SIZE_BYTE, 32'h1000, 32'hFFFF_FFCD, 32'h1000, 32'h0000_00CD, 4'b0001, 1'b0};
        vecs[2]  = '{CACHE_ACCESS_SIZE_BYTE, 32'h1001, 32'h0000_0012, 32'h1000, 32'h0000_1200, 4'b0010, 1'b0};
        vecs[3]  = '{CACHE_ACCESS_SIZE_BYTE, 32'h1002, 32'h0000_0034, 32'h1000, 32'h0034_0000, 4'b0100, 1'b0};
        vecs[4]  = '{CACHE_ACCESS_SIZE_HALF, 32'h2002, 32'h0000_1234, 32'h2000, 32'h1234_0000, 4'b1100, 1'b0};
        vecs[5]  = '{CACHE_ACCESS_SIZE_HALF, 32'h2000, 32'hABCD_9876, 32'h2000, 32'h0000_9876, 4'b0011, 1'b0};
        vecs[6]  = '{CACHE_ACCESS_SIZE_WORD, 32'h2004, 32'hDEAD_BEEF, 32'h2004, 32'hDEAD_BEEF, 4'b1111, 1'b0};
        vecs[7]  = '{CACHE_ACCESS_SIZE_HALF, 32'h4001, 32'h0000_5555, 32'h0,    32'h0,         4'b0000, 1'b1};
        vecs[8]  = '{CACHE_ACCESS_SIZE_WORD, 32'h4002, 32'h1111_2222, 32'h0,    32'h0,         4'b0000, 1'b1};
        vecs[9]  = '{CACHE_ACCESS_SIZE_HALF, 32'h4003, 32'h0000_7777, 32'h0,    32'h0,         4'b0000, 1'b1};
        vecs[10] = '{CACHE_ACCESS_SIZE_WORD, 32'h4001, 32'h3333_4444, 32'h0,    32'h0,         4'b0000, 1'b1};

        reset    = 1'b1;
        inValid  = 1'b0;
        inSize   = CACHE_ACCESS_SIZE_BYTE;
        inAddr   = '0;
        inData   = '0;
        outReady = 1'b0;
        expMis   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        idle(1'b0, 1);
        reset = 1'b0;

        $display("[TB] alignment table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].size, vecs[i].addr, vecs[i].data, 1'b0);
            checkOutput("tbl_valid", 32'(outValid), 32'(!vecs[i].expMis));
            checkOutput("tbl_mis", 32'(misaligned), 32'(vecs[i].expMis));
            if (!vecs[i].expMis) begin
                checkOutput("tbl_addr", outAddr, vecs[i].expAddr);
                checkOutput("tbl_data", outData, vecs[i].expData);
                checkOutput("tbl_be", 32'(outByteEn), 32'(vecs[i].expBe));
            end
            idle(1'b1, 1);
            checkOutput("tbl_empty", 32'(empty), 32'd1);
        end

        $display("[TB] two entries held");
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_HALF, 32'h2002, 32'h0000_1234, 1'b0);
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_WORD, 32'h2004, 32'hDEAD_BEEF, 1'b0);
        checkOutput("two_count", 32'(count), 32'd2);
        checkOutput("two_head_data", outData, 32'h1234_0000);
        idle(1'b1, 1);
        checkOutput("two_second_data", outData, 32'hDEAD_BEEF);
        idle(1'b1, 2);

        $display("[TB] coalescing");
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_BYTE, 32'h3000, 32'h0000_0011, 1'b0);
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_BYTE, 32'h3001, 32'h0000_0022, 1'b0);
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_HALF, 32'h3002, 32'h0000_5566, 1'b0);
        checkOutput("merge_count", 32'(count), 32'd1);
        checkOutput("merge_data", outData, 32'h5566_2211);
        checkOutput("merge_be", 32'(outByteEn), 32'hF);
        idle(1'b1, 2);

        $display("[TB] no merge into departing head");
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_BYTE, 32'h6000, 32'h0000_0011, 1'b0);
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_BYTE, 32'h6001, 32'h0000_0022, 1'b1);
        checkOutput("nomerge_count", 32'(count), 32'd1);
        checkOutput("nomerge_data", outData, 32'h0000_2200);
        checkOutput("nomerge_be", 32'(outByteEn), 32'h2);
        idle(1'b1, 2);

        $display("[TB] fill and drain");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, CACHE_ACCESS_SIZE_WORD, 32'h7000 + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b0);
        end
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_ready", 32'(inReady), 32'd0);
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_WORD, 32'h7010, 32'hBBBB_0000, 1'b0);
        checkOutput("full_hold_count", 32'(count), 32'd4);
        begin
            bit accepted;
            accepted = 1'b0;
            for (int i = 0; i < 8 && !accepted; i++) begin
                applyStimulus(1'b1, CACHE_ACCESS_SIZE_WORD, 32'h7010, 32'hBBBB_0000, 1'b1);
                accepted = lastAccept;
            end
            checkOutput("held_accepted", 32'(accepted), 32'd1);
        end
        idle(1'b1, 6);
        checkOutput("drained_empty", 32'(empty), 32'd1);

        $display("[TB] back-to-back misaligned");
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_HALF, 32'h4001, 32'h0000_1111, 1'b0);
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_WORD, 32'h4002, 32'h2222_3333, 1'b0);
        checkOutput("mis_pulse2", 32'(misaligned), 32'd1);
        checkOutput("mis_count", 32'(count), 32'd0);
        idle(1'b0, 1);
        checkOutput("mis_clear", 32'(misaligned), 32'd0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, CACHE_ACCESS_SIZE_WORD, 32'h9000 + 32'(16*i), 32'h1234_5670 + 32'(i), 1'b0);
        end
        reset = 1'b1;
        applyStimulus(1'b0, CACHE_ACCESS_SIZE_BYTE, 32'h0, 32'h0, 1'b1);
        reset = 1'b0;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_ready", 32'(inReady), 32'd1);
        applyStimulus(1'b1, CACHE_ACCESS_SIZE_WORD, 32'h5000, 32'hCAFE_F00D, 1'b0);
        checkOutput("rst_new_addr", outAddr, 32'h5000);
        checkOutput("rst_new_data", outData, 32'hCAFE_F00D);
        idle(1'b1, 2);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          cache_access_size_t'(2'($urandom_range(0, 2))),
                          32'h8000 + 32'($urandom_range(0, 11)),
                          $urandom(),
                          1'($urandom_range(0, 2) == 0));
        end
        idle(1'b1, 8);
        checkOutput("final_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_store_align_buffer.md
Name: cache_store_align_buffer

Overview:
- Store-side counterpart of the load sign-extend path. Takes byte/half/word store requests from the pipeline and places the data on the correct byte lanes of a cache word.
- Generates per-byte write enables and queues the result in a small FIFO.
- Optionally coalesces consecutive stores to the same word, then issues word-aligned masked writes to the data cache over a valid/ready handshake.

Parameters:
- WORD_SIZE, 32, cache word width in bits; must be 32 (size encoding is byte/half/word).
- ADDR_SIZE, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- COALESCE, 1, 1 = merge a store into the tail entry when the word addresses match.
- localparam OFFSET_SIZE = $clog2(WORD_SIZE/8); BE_SIZE = WORD_SIZE/8.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  store request valid
- in_ready_o  out  1  buffer can accept a request
- in_addr_i  in  ADDR_SIZE  store byte address
- in_data_i  in  WORD_SIZE  store data, right-justified (byte in [7:0], half in [15:0])
- in_size_i  in  cache_access_size_t  CACHE_ACCESS_SIZE_BYTE/HALF/WORD
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  cache accepts head entry
- out_addr_o  out  ADDR_SIZE  word-aligned address (low OFFSET_SIZE bits zero)
- out_data_o  out  WORD_SIZE  lane-aligned data
- out_byte_en_o  out  BE_SIZE  byte write enables
- misaligned_o  out  1  one-cycle pulse: a misaligned request was dropped
- count_o  out  $clog2(DEPTH)+1  current occupancy
- empty_o  out  1  count_o == 0

Behaviour:
- Clock/reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: count_o=0, empty_o=1, out_valid_o=0, misaligned_o=0, read/write pointers=0. Entry storage is not reset.
- Reset mid-operation discards all queued stores. No output handshake completes in the reset cycle.
- Accept: in_ready_o = (count_o != DEPTH). It is combinational from occupancy only; no dependence on out_ready_i.
- Accept occurs when in_valid_i && in_ready_o.
- Alignment, with off = in_addr_i[OFFSET_SIZE-1:0]:
  - BYTE: data = in_data_i[7:0] << 8*off; be = 1 << off.
  - HALF: data = in_data_i[15:0] << 16*off[1]; be = 2'b11 << 2*off[1].
  - WORD: data = in_data_i; be = all ones.
  - Lanes with be=0 carry zero.
- Misalignment: HALF with off[0]=1, or WORD with off!=0.
  - The request is still accepted (handshake completes) but no entry is written.
  - misaligned_o is 1 for exactly the next cycle.
  - Back-to-back misaligned requests give back-to-back pulses.
- Word address = in_addr_i with the low OFFSET_SIZE bits cleared.
- Coalesce condition: COALESCE=1, count_o>0, word address equals the tail entry address, and the tail is not being popped this cycle (not (count_o==1 && out_valid_o && out_ready_i)).
  - Merge: for each lane with new be=1, tail data lane = new lane. Tail be |= new be. count unchanged.
  - Coalescing is only possible when in_ready_o=1; a full buffer never merges.
- Otherwise an accepted aligned request is written at the write pointer.
- Output: out_valid_o = !empty_o. out_* reflect the head entry.
- Pop occurs when out_valid_o && out_ready_i; the read pointer advances.
- Latency: a request accepted in cycle N is visible at the output (if the buffer was empty) in cycle N+1. There is no combinational in→out path.
- Simultaneous push and pop: count unchanged; valid when full (pop frees nothing for the push that cycle since in_ready_o was already 0 — push impossible when full). When count_o==1 and the pop is concurrent, the new store becomes a new entry, not a merge.
- Pointers wrap modulo DEPTH. count_o saturates structurally at DEPTH and never exceeds it.
- Stores leave in program order. Merged stores retain the tail's position.
- out_* must stay stable while out_valid_o && !out_ready_i (the head entry is never modified by a merge unless count_o==1 and it is not being popped; in that case the change is permitted).

Test Plan:
- Reset, then BYTE store, addr 0x1003, data 0x000000AB -> cycle+1: out_valid_o=1, out_addr_o=0x1000, out_data_o=0xAB000000, out_byte_en_o=4'b1000. Pop with out_ready_i=1 -> empty_o=1.
- HALF store at 0x2002, data 0x1234; WORD at 0x2004, data 0xDEADBEEF; out_ready_i=0 -> count_o=2. Head is 0x2000 / 0x12340000 / 4'b1100, then 0x2004 / 0xDEADBEEF / 4'b1111.
- COALESCE=1, out_ready_i=0: BYTE 0x3000 data 0x11, BYTE 0x3001 data 0x22, HALF 0x3002 data 0x5566 -> count_o=1, out_data_o=0x55662211, out_byte_en_o=4'b1111.
- Fill: 4 WORD stores to distinct words with out_ready_i=0 -> in_ready_o=0 and count_o=4. Raise out_ready_i with in_valid_i held -> 4 entries drain in order, each pop re-opens in_ready_o, and the held store is enqueued after the first pop.
- HALF at 0x4001 and WORD at 0x4002 -> two accepted handshakes, misaligned_o pulses 1 cycle each, count_o stays 0.
- 3 entries queued, assert reset_i for 1 cycle -> next cycle count_o=0, out_valid_o=0, in_ready_o=1. A following store at 0x5000 appears at the head.
